// File: rtl/rr_arb2_pkg.sv
// Shared constants and types for the two-channel round-robin arbiter.
package rr_arb2_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/rr_arb2_mux2x1.sv
// Existing 1-bit 2:1 mux cell: y = sel ? b : a.
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Two-channel round-robin arbiter feeding a single registered output slot.
module rr_arb2
  import rr_arb2_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic             last_grant_q;
  logic             gnt_any;
  logic             gnt_sel;
  logic             load_en;
  logic [WIDTH-1:0] mux_y;

  // Grant: contention goes to the channel that did not win last time.
  always_comb begin
    gnt_any = a_valid | b_valid;
    gnt_sel = SEL_A;
    if (a_valid && b_valid) begin
      gnt_sel = ~last_grant_q;
    end else if (b_valid) begin
      gnt_sel = SEL_B;
    end
  end

  assign load_en = (state_q == EMPTY) || y_ready;

  // Readies are held low throughout reset so nothing is consumed then.
  assign a_ready = rst_n & load_en & gnt_any & (gnt_sel == SEL_A);
  assign b_ready = rst_n & load_en & gnt_any & (gnt_sel == SEL_B);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_mux
    mux2x1 u_mux (
      .a   (a_data[i]),
      .b   (b_data[i]),
      .sel (gnt_sel),
      .y   (mux_y[i])
    );
  end

  // Slot next state: a load refills (drain+load in one cycle), otherwise a drain empties.
  always_comb begin
    state_d = state_q;
    if (load_en) begin
      state_d = gnt_any ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      y_data       <= '0;
      sel          <= SEL_A;
      last_grant_q <= SEL_B;
    end else begin
      state_q <= state_d;
      if (load_en && gnt_any) begin
        y_data       <= mux_y;
        sel          <= gnt_sel;
        last_grant_q <= gnt_sel;
      end
    end
  end

  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_arb2.sv
// Directed self-checking bench for rr_arb2 with hand-computed expectations.
module tb_rr_arb2;

  logic       clk;
  logic       rst_n;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       y_valid;
  logic [7:0] y_data;
  logic       y_ready;
  logic       sel;

  int unsigned n_run;
  int unsigned n_fail;

  rr_arb2 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    check({tag, ".y_valid"}, 32'(y_valid), 32'(v));
    check({tag, ".y_data"},  32'(y_data),  32'(d));
    check({tag, ".sel"},     32'(sel),     32'(s));
  endtask

  task automatic check_rdy(input string tag, input logic ar, input logic br);
    #1;
    check({tag, ".a_ready"}, 32'(a_ready), 32'(ar));
    check({tag, ".b_ready"}, 32'(b_ready), 32'(br));
  endtask

  logic [7:0] a_exp_seq [4];
  logic [7:0] single_seq [3];
  int unsigned na;
  int unsigned nb;

  initial begin
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 8'h01;
    b_valid = 1'b1; b_data = 8'h02;
    y_ready = 1'b1;

    // Reset held two cycles with both valids high.
    tick();
    tick();
    check_out("reset", 1'b0, 8'h00, 1'b0);
    check_rdy("reset", 1'b0, 1'b0);

    // Release: A wins the first contention.
    rst_n = 1'b1;
    check_rdy("release", 1'b1, 1'b0);
    tick();
    check_out("release", 1'b1, 8'h01, 1'b0);

    // Single channel A back to back, no bubbles.
    single_seq[0] = 8'h11; single_seq[1] = 8'h22; single_seq[2] = 8'h33;
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_data  = single_seq[i];
      check_rdy("single", 1'b1, 1'b0);
      tick();
      check_out("single", 1'b1, single_seq[i], 1'b0);
    end
    a_valid = 1'b0;
    tick();
    check_out("single_idle", 1'b0, 8'h33, 1'b0);

    // Drain to empty after a lone B word.
    b_valid = 1'b1; b_data = 8'h7E;
    check_rdy("drain_load", 1'b0, 1'b1);
    tick();
    check_out("drain_full", 1'b1, 8'h7E, 1'b1);
    b_valid = 1'b0;
    tick();
    check_out("drain_empty", 1'b0, 8'h7E, 1'b1);
    tick();
    check_out("drain_stay", 1'b0, 8'h7E, 1'b1);

    // Contention: last grant was B, so A, B, A, B.
    a_exp_seq[0] = 8'hA0; a_exp_seq[1] = 8'hB0; a_exp_seq[2] = 8'hA1; a_exp_seq[3] = 8'hB1;
    na = 0; nb = 0;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_data = 8'(8'hA0 + na);
      b_data = 8'(8'hB0 + nb);
      check_rdy("contend", (k % 2) == 0, (k % 2) == 1);
      tick();
      check_out("contend", 1'b1, a_exp_seq[k], 1'((k % 2) == 1));
      if ((k % 2) == 0) na++; else nb++;
    end

    // Backpressure: slot holds 0x5A for 3 cycles.
    b_valid = 1'b0;
    a_valid = 1'b1; a_data = 8'h5A;
    tick();
    check_out("bp_load", 1'b1, 8'h5A, 1'b0);
    y_ready = 1'b0;
    a_valid = 1'b1; a_data = 8'h61;
    b_valid = 1'b1; b_data = 8'h62;
    for (int i = 0; i < 3; i++) begin
      check_rdy("bp_hold", 1'b0, 1'b0);
      tick();
      check_out("bp_hold", 1'b1, 8'h5A, 1'b0);
    end
    y_ready = 1'b1;
    check_rdy("bp_release", 1'b0, 1'b1);
    tick();
    check_out("bp_release", 1'b1, 8'h62, 1'b1);

    // Reset mid-stream with 0x33 in the slot.
    b_valid = 1'b0;
    a_valid = 1'b1; a_data = 8'h33;
    tick();
    check_out("mid_load", 1'b1, 8'h33, 1'b0);
    y_ready = 1'b0;
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 8'hA5;
    b_valid = 1'b1; b_data = 8'hB5;
    check_rdy("mid_reset", 1'b0, 1'b0);
    tick();
    check_out("mid_reset", 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    y_ready = 1'b1;
    check_rdy("mid_resume", 1'b1, 1'b0);
    tick();
    check_out("mid_resume_a", 1'b1, 8'hA5, 1'b0);
    a_data = 8'hA6;
    check_rdy("mid_resume2", 1'b0, 1'b1);
    tick();
    check_out("mid_resume_b", 1'b1, 8'hB5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb2.md
# rr_arb2

Two-channel round-robin arbiter with a single registered output slot. It merges two valid/ready data streams (channel A, channel B) into one output stream and exposes the registered channel select, so the datapath selection is performed by the team's existing 2:1 mux cell. It sits directly upstream of any consumer of a single merged stream and drives the `sel` input of the mux cells it instantiates.

## Interface
- `WIDTH`, 8, data width of each channel and of the output; legal range 1..64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset; sampled on rising `clk`.
- `a_valid`  in  1  channel A holds a word.
- `a_data`  in  WIDTH  channel A word.
- `a_ready`  out  1  channel A word is accepted this cycle.
- `b_valid`  in  1  channel B holds a word.
- `b_data`  in  WIDTH  channel B word.
- `b_ready`  out  1  channel B word is accepted this cycle.
- `y_valid`  out  1  output slot is full.
- `y_data`  out  WIDTH  output word, registered.
- `y_ready`  in  1  downstream takes `y_data` this cycle.
- `sel`  out  1  registered source of the current/last output word: 0 = A, 1 = B.

## Operation
- Transfer on any port: `valid & ready` high at a rising `clk` edge.
- Slot state: EMPTY (`y_valid`=0) or FULL (`y_valid`=1).
- `load_en` = EMPTY or (FULL and `y_ready`).
- Grant, combinational from the valids and `last_grant`:
  - only A valid -> grant A; only B valid -> grant B;
  - both valid -> grant the channel not equal to `last_grant`;
  - neither -> no grant.
- `a_ready` = `load_en` and grant A; `b_ready` = `load_en` and grant B. At most one ready is high in any cycle.
- On an edge with a grant and `load_en`:
  - `y_data` <= granted word;
  - `sel` <= granted channel;
  - `last_grant` <= granted channel;
  - slot becomes FULL.
- On an edge with `load_en`, FULL, `y_ready`=1 and no grant: slot becomes EMPTY. `y_data` and `sel` hold their values.
- FULL and `y_ready`=0: everything holds. Both readies are 0 (backpressure).
- `last_grant` changes only on a granted load, never on a single-requester transfer that matches it.
- Reset values: `y_valid`=0, `y_data`=0, `sel`=0, `last_grant`=1 (B), so A wins the first contention. `a_ready` and `b_ready` are forced to 0 while `rst_n`=0.
- Reset mid-operation: any word in the slot is discarded. Words presented on A/B are not accepted in the reset cycle.

## Timing
- Latency: a word accepted at edge N appears on `y_data` with `y_valid`=1 after edge N.
- Throughput: one word per cycle while `y_ready`=1 and either input is valid.
- Simultaneous drain and load in one cycle is required, with no bubble.
- Under continuous contention with `y_ready`=1, output alternates A, B, A, B…
- `a_ready`/`b_ready` depend combinationally on `a_valid`, `b_valid` and `y_ready`. Upstream must not make valid depend on ready.
- `y_valid`, `y_data` and `sel` are pure register outputs.
- Valid-hold rule: once a valid is raised, it and its data hold until transfer. The block does not check this.

## Structure
- Shared package holds:
  - channel-select constants `SEL_A`=0 and `SEL_B`=1;
  - the slot-state encoding (EMPTY/FULL).
- Sub-module: the existing 1-bit `mux2x1` cell, instantiated WIDTH times in a generate loop. Inputs are `a_data[i]` and `b_data[i]`; select is the combinational grant. Its output feeds the `y_data` register.
- Arbiter logic, `load_en` and the slot register live in `rr_arb2`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with both valids high -> `y_valid`=0, `y_data`=0, `sel`=0, both readies 0. Release -> first word is A's.
- Single channel: A sends 0x11, 0x22, 0x33 back to back with `y_ready`=1 -> `y_data` shows 0x11, 0x22, 0x33 on consecutive cycles, `sel`=0, no bubbles.
- Contention: A and B always valid (A=0xA0+n, B=0xB0+n), `y_ready`=1 -> output is 0xA0, 0xB0, 0xA1, 0xB1, with `sel` toggling 0, 1, 0, 1.
- Backpressure: slot FULL with 0x5A, `y_ready`=0 for 3 cycles, both valid -> `y_data` holds 0x5A and both readies are 0. Release `y_ready` -> next word loads on the same edge that drains 0x5A.
- Drain to empty: one word B=0x7E, then no valids, `y_ready`=1 -> `y_valid` drops one cycle after 0x7E is shown, `sel` stays 1.
- Reset mid-stream: `rst_n`=0 while FULL with 0x33 -> next cycle `y_valid`=0. After release, contention resumes with A first.
